param_stack: RTL and testbench
==============================

Name: param_stack

Overview:
Parametrised successor to the calculator operand stack. Top and second element are held in registers (`top`, `next`); deeper entries live in an inferred synchronous single-port RAM.
- Supports push, pop, binary-op replace (pop two, push result), dup, swap and clear through a valid/ready command interface.
- Exposes both operands so the ALU can read them in parallel.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 512, maximum number of stack entries. Must be at least 3; RAM holds DEPTH-2 words.
- SW, $clog2(DEPTH+1), width of `size` (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command (state IDLE).
- cmd_op  in  3  operation code (package enum).
- in_num  in  WIDTH  operand for PUSH and REPLACE2.
- top  out  WIDTH  entry size-1; 0 if size<1.
- next  out  WIDTH  entry size-2; 0 if size<2.
- size  out  SW  current entry count.
- error  out  1  last accepted command was illegal.
- peak  out  SW  high-water mark; exists only with the optional feature.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: size=0, top=0, next=0, error=0, state=IDLE, cmd_ready=1. Reset overrides everything, including mid-READ; a pending RAM read is discarded.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state==IDLE). A command held while not ready is not lost; the master keeps it asserted.
- Error rule: `error` updates on every accepted command (1 = illegal, 0 = legal). On an illegal command, size/top/next do not change.
- States: IDLE, READ.
  - READ lasts exactly one cycle: RAM data returns into `next`, then state goes back to IDLE.
  - Every other op completes in IDLE within one cycle.
- PUSH:
  - Illegal if size==DEPTH.
  - Otherwise: if size>=2, write `next` into RAM[size-2]. Then next<=top, top<=in_num, size+1.
- POP:
  - Illegal if size==0.
  - size 1: top<=0, size<=0.
  - size 2: top<=next, next<=0, size<=1.
  - size >=3: top<=next, issue a read of RAM[size-3], size-1, go to READ.
- REPLACE2 (binary-op result):
  - Illegal if size<2.
  - size 2: top<=in_num, next<=0, size<=1.
  - size >=3: top<=in_num, read RAM[size-3], size-1, go to READ.
- DUP:
  - Illegal if size==0 or size==DEPTH.
  - Otherwise identical to PUSH with in_num replaced by `top`.
- SWAP:
  - Illegal if size<2.
  - Otherwise exchange top and next in one cycle.
- CLEAR:
  - Always legal. size, top and next go to 0; RAM contents are left stale.
- Undefined opcode: error=1, no state change.
- Latency:
  - PUSH, DUP, SWAP, CLEAR and the short POP/REPLACE2 cases: outputs valid the cycle after acceptance.
  - POP/REPLACE2 with size>=3: 2 cycles.
- size and top update at acceptance. `next` is only guaranteed while cmd_ready=1.
- Arithmetic: RAM address is SW-1 bits, computed from size without wrap. The legality checks guarantee addresses stay in 0..DEPTH-3.

Optional Feature:
- Macro: PARAM_STACK_PEAK_EN.
- Defined: `peak` port present; reset to 0. Whenever size exceeds peak, peak<=size. CLEAR does not reset peak; only `reset` does.
- Undefined: no `peak` port, no register.

Decomposition:
- Shared package `calc_stack_pkg`:
  - Op enum: OP_PUSH=0, OP_POP=1, OP_REPLACE2=2, OP_DUP=3, OP_SWAP=4, OP_CLEAR=5.
  - State enum: ST_IDLE, ST_READ.
  - Constant OP_W=3.
- One sub-module, `stack_ram`: parametrised WIDTH/DEPTH-2 synchronous RAM with enable and write-enable, 1-cycle read latency, write does not update the read output.

Test Plan:
- Push 1..5 (WIDTH=32, DEPTH=8) -> size=5, top=5, next=4; then POP -> cmd_ready low for 1 cycle, then top=4, next=3, size=4.
- DEPTH=8: push 8 values, then push 9 -> error=1, size=8, top unchanged; then POP -> error=0, size=7.
- Stack [10,20,30], REPLACE2 with in_num=50 -> size=2, top=50, next=10; SWAP -> top=10, next=50.
- Empty stack: POP, SWAP, REPLACE2 each -> error=1, size=0, top=0; DUP with top=7 at size=1 -> size=2, top=7, next=7.
- Assert reset during READ (POP from size 4) -> next cycle size=0, top=0, next=0, cmd_ready=1, error=0.
- PARAM_STACK_PEAK_EN defined: push 6, pop 4, CLEAR -> peak=6, size=0.

Source files
------------

// File: rtl/calc_stack_pkg.sv
// ----------------------------------------------------------------------------
// calc_stack_pkg
// Shared definitions for the calculator operand stack family.
//   OP_W    : width of the command opcode field
//   op_e    : stack command opcodes (values 6 and 7 are undefined)
//   state_e : control states of param_stack (IDLE / READ)
//   op_is_defined() : true for opcodes that map to a real operation
// ----------------------------------------------------------------------------
package calc_stack_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PUSH     = 3'd0,
        OP_POP      = 3'd1,
        OP_REPLACE2 = 3'd2,
        OP_DUP      = 3'd3,
        OP_SWAP     = 3'd4,
        OP_CLEAR    = 3'd5
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_e;

    function automatic logic op_is_defined(input logic [OP_W-1:0] op);
        return (op <= OP_CLEAR);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// ----------------------------------------------------------------------------
// stack_ram
// Single-port synchronous RAM holding the stack entries below `top`/`next`.
// One-cycle read latency; a write cycle leaves the read register untouched.
// Ports:
//   clk   : clock
//   en    : port enable (read or write this cycle)
//   we    : write enable (valid with en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module stack_ram #(
    parameter int WIDTH = 32,
    parameter int WORDS = 510,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/param_stack.sv
// ----------------------------------------------------------------------------
// param_stack
// Operand stack for the calculator datapath. The two newest entries live in
// registers (`top`, `next`) so the ALU can read both at once; older entries
// spill into a synchronous RAM of DEPTH-2 words.
//
// Optional feature: define PARAM_STACK_PEAK_EN to add the `peak` output, a
// high-water mark of `size` cleared only by reset.
//
// Ports:
//   clk       : clock
//   reset     : synchronous, active-high reset
//   cmd_valid : command request
//   cmd_ready : command can be accepted (IDLE state)
//   cmd_op    : opcode (calc_stack_pkg::op_e)
//   in_num    : operand for PUSH / REPLACE2
//   top       : newest entry (0 when empty)
//   next      : second entry (0 when size < 2); valid while cmd_ready
//   size      : number of entries
//   error     : last accepted command was illegal
//   peak      : high-water mark of size (PARAM_STACK_PEAK_EN only)
// ----------------------------------------------------------------------------
module param_stack
    import calc_stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] in_num,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [SW-1:0]    size,
    output logic             error
`ifdef PARAM_STACK_PEAK_EN
    ,
    output logic [SW-1:0]    peak
`endif
);

    localparam int AW = SW - 1;
    localparam int RAM_WORDS = DEPTH - 2;
    localparam logic [SW-1:0] SIZE_FULL = SW'(DEPTH);
    localparam logic [SW-1:0] SIZE_ONE  = SW'(1);
    localparam logic [SW-1:0] SIZE_TWO  = SW'(2);
    localparam logic [SW-1:0] SIZE_THREE = SW'(3);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] top_reg, top_next;
    logic [WIDTH-1:0] next_reg, next_next;
    logic [SW-1:0]    size_reg, size_next;
    logic             error_reg, error_next;

    logic             accept;
    logic             start_read;
    logic             ram_en;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    // Spill slot for `next` on a push and refill slot on a pop. The legality
    // checks keep both in 0..DEPTH-3, so plain truncation is safe.
    logic [AW-1:0]    spill_addr;
    logic [AW-1:0]    fill_addr;

    assign spill_addr = AW'(size_reg - SIZE_TWO);
    assign fill_addr  = AW'(size_reg - SIZE_THREE);
    assign accept     = cmd_valid && cmd_ready;

    stack_ram #(
        .WIDTH (WIDTH),
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Control FSM: next-state logic. READ always lasts a single cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = start_read ? ST_READ : ST_IDLE;
            ST_READ: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control FSM: outputs
    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: command decode and RAM access
    // ------------------------------------------------------------------
    always_comb begin
        top_next   = top_reg;
        next_next  = next_reg;
        size_next  = size_reg;
        error_next = error_reg;
        start_read = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = spill_addr;
        ram_wdata  = next_reg;

        if (state_reg == ST_READ) begin
            // Refill `next` from the entry that has just become second.
            next_next = ram_rdata;
        end else if (accept) begin
            error_next = 1'b0;
            case (cmd_op)
                OP_PUSH, OP_DUP: begin
                    if ((size_reg == SIZE_FULL) ||
                        ((cmd_op == OP_DUP) && (size_reg == '0))) begin
                        error_next = 1'b1;
                    end else begin
                        if (size_reg >= SIZE_TWO) begin
                            ram_en   = 1'b1;
                            ram_we   = 1'b1;
                            ram_addr = spill_addr;
                        end
                        next_next = top_reg;
                        top_next  = (cmd_op == OP_PUSH) ? in_num : top_reg;
                        size_next = size_reg + SIZE_ONE;
                    end
                end
                OP_POP: begin
                    if (size_reg == '0) begin
                        error_next = 1'b1;
                    end else if (size_reg == SIZE_ONE) begin
                        top_next  = '0;
                        size_next = '0;
                    end else if (size_reg == SIZE_TWO) begin
                        top_next  = next_reg;
                        next_next = '0;
                        size_next = SIZE_ONE;
                    end else begin
                        top_next   = next_reg;
                        size_next  = size_reg - SIZE_ONE;
                        ram_en     = 1'b1;
                        ram_addr   = fill_addr;
                        start_read = 1'b1;
                    end
                end
                OP_REPLACE2: begin
                    if (size_reg < SIZE_TWO) begin
                        error_next = 1'b1;
                    end else if (size_reg == SIZE_TWO) begin
                        top_next  = in_num;
                        next_next = '0;
                        size_next = SIZE_ONE;
                    end else begin
                        top_next   = in_num;
                        size_next  = size_reg - SIZE_ONE;
                        ram_en     = 1'b1;
                        ram_addr   = fill_addr;
                        start_read = 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (size_reg < SIZE_TWO) begin
                        error_next = 1'b1;
                    end else begin
                        top_next  = next_reg;
                        next_next = top_reg;
                    end
                end
                OP_CLEAR: begin
                    // RAM contents are left stale; size gates every read.
                    top_next  = '0;
                    next_next = '0;
                    size_next = '0;
                end
                default: begin
                    error_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_reg   <= '0;
            next_reg  <= '0;
            size_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            top_reg   <= top_next;
            next_reg  <= next_next;
            size_reg  <= size_next;
            error_reg <= error_next;
        end
    end

`ifdef PARAM_STACK_PEAK_EN
    logic [SW-1:0] peak_reg;

    // Compare against the incoming size so peak moves in step with size.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_reg <= '0;
        end else if (size_next > peak_reg) begin
            peak_reg <= size_next;
        end
    end

    assign peak = peak_reg;
`endif

    assign top   = top_reg;
    assign next  = next_reg;
    assign size  = size_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
    import calc_stack_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int SW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [W-1:0]     in_num;
    logic [W-1:0]     top;
    logic [W-1:0]     next;
    logic [SW-1:0]    size;
    logic             error;
`ifdef PARAM_STACK_PEAK_EN
    logic [SW-1:0]    peak;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    param_stack #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .in_num    (in_num),
        .top       (top),
        .next      (next),
        .size      (size),
        .error     (error)
`ifdef PARAM_STACK_PEAK_EN
        ,
        .peak      (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [W-1:0]    num;
        logic [W-1:0]    e_top;
        logic [W-1:0]    e_next;
        int              e_size;
        bit              e_err;
        int              e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [OP_W-1:0] op, input logic [W-1:0] num,
                                input logic [W-1:0] e_top, input logic [W-1:0] e_next,
                                input int e_size, input bit e_err, input int e_busy);
        vec_t v;
        v.op = op; v.num = num; v.e_top = e_top; v.e_next = e_next;
        v.e_size = e_size; v.e_err = e_err; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Issue one command at a negedge; return the number of not-ready cycles
    // seen after acceptance (bounded).
    task automatic do_cmd(input logic [OP_W-1:0] op, input logic [W-1:0] num,
                          output int busy);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got cmd_ready=0, expected 1");
        end
        cmd_op    = op;
        in_num    = num;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        busy = 0;
        while (!cmd_ready && busy < 5) begin
            busy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int busy;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        in_num    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_size",  W'(size), 0);
        check("reset_top",   top, 0);
        check("reset_next",  next, 0);
        check("reset_error", W'(error), 0);
        check("reset_ready", W'(cmd_ready), 1);
        $display("reset: size=%0d top=%0d next=%0d err=%0d ready=%0d",
                 size, top, next, error, cmd_ready);

        // Push 1..5 then POP (one READ cycle)
        for (int i = 1; i <= 5; i++) add(OP_PUSH, W'(i), W'(i), W'(i - 1), i, 0, 0);
        add(OP_POP, 0, 4, 3, 4, 0, 1);
        // Fill to DEPTH, overflow, then pop twice through the RAM
        add(OP_CLEAR, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(OP_PUSH, W'(i * 11), W'(i * 11), W'((i - 1) * 11), i, 0, 0);
        add(OP_PUSH, 9, 88, 77, 8, 1, 0);
        add(OP_DUP, 0, 88, 77, 8, 1, 0);
        add(OP_POP, 0, 77, 66, 7, 0, 1);
        add(OP_POP, 0, 66, 55, 6, 0, 1);
        // [10,20,30] REPLACE2 then SWAP
        add(OP_CLEAR, 0, 0, 0, 0, 0, 0);
        add(OP_PUSH, 10, 10, 0, 1, 0, 0);
        add(OP_PUSH, 20, 20, 10, 2, 0, 0);
        add(OP_PUSH, 30, 30, 20, 3, 0, 0);
        add(OP_REPLACE2, 50, 50, 10, 2, 0, 1);
        add(OP_SWAP, 0, 10, 50, 2, 0, 0);
        add(OP_REPLACE2, 99, 99, 0, 1, 0, 0);
        add(OP_POP, 0, 0, 0, 0, 0, 0);
        // Empty-stack illegal ops, undefined opcode, DUP at size 1
        add(OP_POP, 0, 0, 0, 0, 1, 0);
        add(OP_SWAP, 0, 0, 0, 0, 1, 0);
        add(OP_REPLACE2, 5, 0, 0, 0, 1, 0);
        add(OP_DUP, 0, 0, 0, 0, 1, 0);
        add(OP_PUSH, 7, 7, 0, 1, 0, 0);
        add(3'd6, 1, 7, 0, 1, 1, 0);
        add(OP_DUP, 0, 7, 7, 2, 0, 0);
        add(OP_SWAP, 0, 7, 7, 2, 0, 0);

        foreach (vecs[k]) begin
            do_cmd(vecs[k].op, vecs[k].num, busy);
            $display("vec %0d: op=%0d num=%0d -> top=%0d next=%0d size=%0d err=%0d busy=%0d",
                     k, vecs[k].op, vecs[k].num, top, next, size, error, busy);
            check($sformatf("v%0d_top", k),   top, vecs[k].e_top);
            check($sformatf("v%0d_next", k),  next, vecs[k].e_next);
            check($sformatf("v%0d_size", k),  W'(size), W'(vecs[k].e_size));
            check($sformatf("v%0d_error", k), W'(error), W'(vecs[k].e_err));
            check($sformatf("v%0d_busy", k),  W'(busy), W'(vecs[k].e_busy));
        end

        // Reset asserted while in READ (POP from size 4)
        do_cmd(OP_CLEAR, 0, busy);
        for (int i = 1; i <= 4; i++) do_cmd(OP_PUSH, W'(i), busy);
        do_cmd(3'd7, 0, busy);
        cmd_op    = OP_POP;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rd_ready_low", W'(cmd_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset in READ: size=%0d top=%0d next=%0d err=%0d ready=%0d",
                 size, top, next, error, cmd_ready);
        check("rr_size",  W'(size), 0);
        check("rr_top",   top, 0);
        check("rr_next",  next, 0);
        check("rr_error", W'(error), 0);
        check("rr_ready", W'(cmd_ready), 1);
        // Stale RAM read must not resurface one cycle later
        @(negedge clk);
        check("rr_next_late", next, 0);

`ifdef PARAM_STACK_PEAK_EN
        check("peak_reset", W'(peak), 0);
        for (int i = 1; i <= 6; i++) do_cmd(OP_PUSH, W'(i), busy);
        for (int i = 0; i < 4; i++) do_cmd(OP_POP, 0, busy);
        do_cmd(OP_CLEAR, 0, busy);
        $display("peak: peak=%0d size=%0d", peak, size);
        check("peak_val",  W'(peak), 6);
        check("peak_size", W'(size), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
